// File: rtl/ring_pkg.sv
// Shared types and default parameters for the ring-counter decoder.
// Holds the acquisition state encoding used by ring_decoder.
package ring_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_ERR_W    = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_check.sv
// Combinational classifier: flags an exactly-one-bit-set code and
// returns the binary position of that bit.
module onehot_check #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] ring_in,
  output logic             is_onehot,
  output logic [IDX_W-1:0] index
);

  int unsigned ones;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ones  = 0;
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        ones  = ones + 1;
        index = IDX_W'(i);
      end
    end
    is_onehot = (ones == 1);
  end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter code decoder: acquires lock on a rotating one-hot code,
// reports the bit position, and counts malformed or out-of-order samples.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         ring_in,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     err_onehot,
  output logic                     err_seq,
  output logic [ERR_W-1:0]         err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t           state;
  logic [WIDTH-1:0] code;
  logic [CNT_W-1:0] good_cnt;
  logic             is_onehot;
  logic [IDX_W-1:0] oh_idx;
  logic [WIDTH-1:0] expected;

  onehot_check #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_onehot_check (
    .ring_in   (ring_in),
    .is_onehot (is_onehot),
    .index     (oh_idx)
  );

  assign expected = {code[WIDTH-2:0], code[WIDTH-1]};

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      code       <= '0;
      good_cnt   <= '0;
      idx        <= '0;
      idx_valid  <= 1'b0;
      locked     <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_count  <= '0;
    end else begin
      idx_valid  <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      if (in_valid) begin
        if (!is_onehot) begin
          err_onehot <= 1'b1;
          if (err_count != '1) err_count <= err_count + ERR_ONE;
          state    <= HUNT;
          good_cnt <= '0;
          locked   <= 1'b0;
        end else begin
          idx <= oh_idx;
          unique case (state)
            HUNT: begin
              code     <= ring_in;
              good_cnt <= CNT_ONE;
              if (LOCK_CNT == 1) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                idx_valid <= 1'b1;
              end else begin
                state <= SYNC;
              end
            end
            SYNC: begin
              code <= ring_in;
              if (ring_in == expected) begin
                good_cnt <= good_cnt + CNT_ONE;
                if ((good_cnt + CNT_ONE) == LOCK_TGT) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  idx_valid <= 1'b1;
                end
              end else begin
                // Any other one-hot code becomes the new reference.
                good_cnt <= CNT_ONE;
              end
            end
            LOCKED: begin
              if (ring_in == expected) begin
                code      <= ring_in;
                idx_valid <= 1'b1;
              end else begin
                err_seq <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_ONE;
                state    <= HUNT;
                good_cnt <= '0;
                locked   <= 1'b0;
              end
            end
            default: begin
              state    <= HUNT;
              good_cnt <= '0;
              locked   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Directed self-checking bench for ring_decoder (WIDTH=4, LOCK_CNT=3, ERR_W=8).
module tb_ring_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] ring_in;
  logic [1:0] idx;
  logic       idx_valid;
  logic       locked;
  logic       err_onehot;
  logic       err_seq;
  logic [7:0] err_count;

  int vectors;
  int miscompares;

  ring_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .ring_in    (ring_in),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .locked     (locked),
    .err_onehot (err_onehot),
    .err_seq    (err_seq),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int e_idx, input bit e_iv, input bit e_lk,
                            input bit e_eoh, input bit e_esq, input int e_cnt);
    check({tag, ".idx"},        32'(idx),        32'(e_idx));
    check({tag, ".idx_valid"},  32'(idx_valid),  32'(e_iv));
    check({tag, ".locked"},     32'(locked),     32'(e_lk));
    check({tag, ".err_onehot"}, 32'(err_onehot), 32'(e_eoh));
    check({tag, ".err_seq"},    32'(err_seq),    32'(e_esq));
    check({tag, ".err_count"},  32'(err_count),  32'(e_cnt));
  endtask

  // Apply one sample; outputs are sampled 1 time unit after the capturing edge.
  task automatic step(input bit v, input logic [3:0] code);
    @(negedge clk);
    in_valid = v;
    ring_in  = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    ring_in     = 4'b0001;

    // Samples presented during reset must be ignored.
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Acquisition: 0001, 0010, 0100 -> lock on the third sample.
    step(1, 4'b0001); expect_out("acq1", 0, 0, 0, 0, 0, 0);
    step(1, 4'b0010); expect_out("acq2", 1, 0, 0, 0, 0, 0);
    step(1, 4'b0100); expect_out("acq3", 2, 1, 1, 0, 0, 0);

    // Idle cycle with a bad code on the bus: nothing changes, pulses low.
    step(0, 4'b1111); expect_out("gap", 2, 0, 1, 0, 0, 0);

    // Wrap 1000 -> 0001 while locked.
    step(1, 4'b1000); expect_out("wrap1", 3, 1, 1, 0, 0, 0);
    step(1, 4'b0001); expect_out("wrap2", 0, 1, 1, 0, 0, 0);
    step(1, 4'b0010); expect_out("lk0010", 1, 1, 1, 0, 0, 0);

    // Out-of-sequence one-hot, then a non-one-hot code.
    step(1, 4'b1000); expect_out("errseq", 3, 0, 0, 0, 1, 1);
    step(1, 4'b0011); expect_out("erroh", 3, 0, 0, 1, 0, 2);

    // Reference restart in SYNC.
    step(1, 4'b0001); expect_out("rs1", 0, 0, 0, 0, 0, 2);
    step(1, 4'b0010); expect_out("rs2", 1, 0, 0, 0, 0, 2);
    step(1, 4'b1000); expect_out("rs3", 3, 0, 0, 0, 0, 2);
    step(1, 4'b0001); expect_out("rs4", 0, 0, 0, 0, 0, 2);
    step(1, 4'b0010); expect_out("rs5", 1, 1, 1, 0, 0, 2);

    // Mid-lock reset with an in_valid gap: outputs clear at once.
    step(0, 4'b0100); expect_out("pre_rst", 1, 0, 1, 0, 0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    expect_out("rst_hold", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0100 would have continued the old sequence; it must start a fresh hunt.
    step(1, 4'b0100); expect_out("relock1", 2, 0, 0, 0, 0, 0);
    step(1, 4'b1000); expect_out("relock2", 3, 0, 0, 0, 0, 0);
    step(1, 4'b0001); expect_out("relock3", 0, 1, 1, 0, 0, 0);

    // Saturation: a stream of 0000 samples.
    step(1, 4'b0000); expect_out("sat1", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 253; i++) step(1, 4'b0000);
    expect_out("sat254", 0, 0, 0, 1, 0, 254);
    step(1, 4'b0000); expect_out("sat255", 0, 0, 0, 1, 0, 255);
    for (int i = 0; i < 5; i++) step(1, 4'b0000);
    expect_out("sat_hold", 0, 0, 0, 1, 0, 255);
    step(0, 4'b0000); expect_out("sat_idle", 0, 0, 0, 0, 0, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, ring code width (>=2).
REQ-002 SHALL have parameter LOCK_CNT, default 3, consecutive in-sequence samples required to declare lock (>=1).
REQ-003 SHALL have parameter ERR_W, default 8, error counter width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  ring_in sampled this cycle when high.
REQ-007 SHALL have port ring_in  input  WIDTH  received ring-counter code.
REQ-008 SHALL have port idx  output  clog2(WIDTH)  binary position of the set bit of the last valid one-hot sample.
REQ-009 SHALL have port idx_valid  output  1  one-cycle pulse, idx updated from a sample accepted in LOCKED.
REQ-010 SHALL have port locked  output  1  high while FSM in LOCKED.
REQ-011 SHALL have port err_onehot  output  1  one-cycle pulse, sample not exactly one-hot.
REQ-012 SHALL have port err_seq  output  1  one-cycle pulse, one-hot sample out of sequence while LOCKED.
REQ-013 SHALL have port err_count  output  ERR_W  saturating count of erroneous samples.

Function
REQ-014 SHALL treat a sample as one-hot iff exactly one bit of ring_in is set.
REQ-015 SHALL define expected next code as previous accepted code rotated left by one (bit WIDTH-1 wraps to bit 0); 1000 -> 0001 for WIDTH=4.
REQ-016 SHALL register all outputs; outputs reflect a sample in the cycle after in_valid is high (latency 1).
REQ-017 SHALL hold FSM state, stored code, idx and counters unchanged, and drive all pulses low, in cycles with in_valid low.
REQ-018 SHALL implement states HUNT, SYNC, LOCKED.
REQ-019 HUNT: one-hot sample -> store code, good_cnt=1, go SYNC (go directly to LOCKED if LOCK_CNT=1); non-one-hot -> stay HUNT.
REQ-020 SYNC: sample == expected -> store, good_cnt+1, go LOCKED when good_cnt reaches LOCK_CNT; other one-hot -> store as new reference, good_cnt=1, stay SYNC; non-one-hot -> go HUNT.
REQ-021 LOCKED: sample == expected -> store, stay LOCKED, pulse idx_valid; other one-hot -> pulse err_seq, go HUNT; non-one-hot -> go HUNT.
REQ-022 SHALL pulse idx_valid also for the sample that causes entry to LOCKED.
REQ-023 SHALL pulse err_onehot for every non-one-hot sample in any state; err_onehot and err_seq SHALL never assert together.
REQ-024 SHALL increment err_count by exactly one per sample that raises err_onehot or err_seq, saturating at all-ones.
REQ-025 SHALL update idx on every one-hot sample in any state; idx unchanged on non-one-hot samples.
REQ-026 SHALL accept back-to-back in_valid samples every cycle with no stall.

Reset
REQ-027 SHALL on rst_n low asynchronously force HUNT, stored code 0, good_cnt 0, idx 0, idx_valid 0, locked 0, err_onehot 0, err_seq 0, err_count 0.
REQ-028 SHALL, on reset mid-lock, discard all sequence history and require full re-acquisition after release.
REQ-029 SHALL ignore in_valid during reset; first sample evaluated is the first rising edge with rst_n high.

Structure
REQ-030 SHALL place state enum (HUNT/SYNC/LOCKED) and default parameter constants in shared package ring_pkg.
REQ-031 SHALL instantiate one combinational sub-module onehot_check (ring_in -> is_onehot, binary index).

Verification (WIDTH=4, LOCK_CNT=3)
REQ-032 Reset, then 0001,0010,0100 valid on consecutive cycles -> locked=1 one cycle after 0100, idx=2, idx_valid pulses once, err_count=0.
REQ-033 While locked, drive 1000 then 0001 -> wrap accepted, idx 3 then 0, idx_valid pulses twice, locked stays 1.
REQ-034 While locked (last 0010), drive 1000 -> err_seq pulse, locked=0, err_count+1; drive 0011 -> err_onehot pulse, err_count+1.
REQ-035 In SYNC after 0001,0010, drive 1000 then 0001,0010 -> locked only after the latter 0010 (reference restarted at 1000).
REQ-036 Drive 256+ consecutive 0000 samples with ERR_W=8 -> err_count saturates at 255, no wrap.
REQ-037 Assert rst_n low for one cycle while locked with in_valid gaps -> all outputs 0 immediately, relock needs 3 new in-sequence samples.
